// File: rtl/embcpumem_pio_pkg.sv
// embcpumem_pio_pkg: register map and edge-type encodings shared by the input PIO.
`default_nettype none

package embcpumem_pio_pkg;

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_type_e;

endpackage

`default_nettype wire

// File: rtl/embcpumem_pio_debounce.sv
// embcpumem_pio_debounce: single-bit filter; output follows input only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement.
`default_nettype none

module embcpumem_pio_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic dout
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          dout_q, dout_d;

   always_comb begin
      cnt_d  = '0;
      dout_d = dout_q;
      if (din != dout_q) begin
         if (cnt_q == CNT_LAST) begin
            dout_d = din;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         dout_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

`default_nettype wire

// File: rtl/embcpumem_pio_in.sv
// embcpumem_pio_in: Avalon-MM input PIO with 2-flop sync, sticky edge capture and
// maskable level irq. Define PIO_IN_DEBOUNCE_EN to insert a per-bit debounce filter.
`default_nettype none

module embcpumem_pio_in
   import embcpumem_pio_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int EDGE_TYPE       = 0,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam edge_type_e ETYPE = edge_type_e'(EDGE_TYPE[1:0]);

   logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] filt;
   logic [WIDTH-1:0] rise, fall, edge_det;
   logic [WIDTH-1:0] clr_bits;
   logic [WIDTH-1:0] rd_sel;
   logic             wr_strobe;
   logic             unused_wdata;

   assign unused_wdata = ^writedata;

`ifdef PIO_IN_DEBOUNCE_EN
   for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
      embcpumem_pio_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .reset_n(reset_n),
         .din    (sync2_q[i]),
         .dout   (filt[i])
      );
   end
`else
   assign filt = sync2_q;
`endif

   assign rise = filt & ~prev_q;
   assign fall = ~filt & prev_q;

   always_comb begin
      edge_det = rise;
      case (ETYPE)
         EDGE_FALL: edge_det = fall;
         EDGE_ANY:  edge_det = rise | fall;
         default:   edge_det = rise;
      endcase
   end

   assign wr_strobe = chipselect & ~write_n;

   // A fresh edge overrides a same-cycle W1C so no event is ever lost.
   always_comb begin
      clr_bits = '0;
      mask_d   = mask_q;
      if (wr_strobe && address == ADDR_EDGE_CAP) begin
         clr_bits = writedata[WIDTH-1:0];
      end
      if (wr_strobe && address == ADDR_IRQ_MASK) begin
         mask_d = writedata[WIDTH-1:0];
      end
      cap_d = edge_det | (cap_q & ~clr_bits);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         mask_q  <= '0;
         cap_q   <= '0;
      end else begin
         sync1_q <= in_port;
         sync2_q <= sync1_q;
         prev_q  <= filt;
         mask_q  <= mask_d;
         cap_q   <= cap_d;
      end
   end

   always_comb begin
      rd_sel = '0;
      case (address)
         ADDR_DATA:     rd_sel = filt;
         ADDR_IRQ_MASK: rd_sel = mask_q;
         ADDR_EDGE_CAP: rd_sel = cap_q;
         default:       rd_sel = '0;
      endcase
   end

   assign readdata = chipselect ? 32'(rd_sel) : 32'd0;
   assign irq      = |(cap_q & mask_q);

endmodule

`default_nettype wire

// File: tb/tb_embcpumem_pio_in.sv
// tb_embcpumem_pio_in: directed stimulus with a read scoreboard for the input PIO.
`default_nettype none

module tb_embcpumem_pio_in;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic        irq;

   typedef struct {
      string       name;
      logic [31:0] rd;
      logic        irq;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   embcpumem_pio_in #(
      .WIDTH          (8),
      .EDGE_TYPE      (0),
      .DEBOUNCE_CYCLES(16)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .in_port   (in_port),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   // Monitor: every selected read cycle pops one expectation.
   always @(negedge clk) begin
      if (chipselect && write_n) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_read: readdata=%h with no expectation queued", readdata);
         end else begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (readdata !== e.rd) begin
               n_bad++;
               $display("FAIL %s: readdata=%h required %h", e.name, readdata, e.rd);
            end
            n_cmp++;
            if (irq !== e.irq) begin
               n_bad++;
               $display("FAIL %s_irq: irq=%b required %b", e.name, irq, e.irq);
            end
         end
      end else if (!chipselect) begin
         n_cmp++;
         if (readdata !== 32'd0) begin
            n_bad++;
            $display("FAIL cs_low_zero: readdata=%h required 00000000", readdata);
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         chipselect = 1'b0;
         write_n    = 1'b1;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp_rd, input logic exp_irq,
                     input string name);
      exp_t e;
      e.name = name;
      e.rd   = exp_rd;
      e.irq  = exp_irq;
      q.push_back(e);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 3'd0;
      writedata  = 32'd0;
      in_port    = 8'h00;
      @(posedge clk);
      #1;
      for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, 1'b0, $sformatf("reset_rd%0d", a));
      reset_n = 1'b1;
      idle(3);

`ifdef PIO_IN_DEBOUNCE_EN
      for (int k = 0; k < 8; k++) begin
         in_port[0] = ~in_port[0];
         for (int j = 0; j < 5; j++) rd(3'd0, 32'd0, 1'b0, "db_glitch");
      end
      idle(4);
      rd(3'd3, 32'd0, 1'b0, "db_nocap");
      in_port = 8'h01;
      idle(17);
      rd(3'd0, 32'd0, 1'b0, "db_h17");
      rd(3'd0, 32'd1, 1'b0, "db_h18");
      rd(3'd3, 32'd1, 1'b0, "db_cap");
`else
      // Change lands in cycle 0: DATA valid in cycle 2, capture in cycle 3.
      in_port = 8'hA5;
      rd(3'd0, 32'd0, 1'b0, "data_c0");
      rd(3'd3, 32'd0, 1'b0, "cap_c1");
      rd(3'd0, 32'hA5, 1'b0, "data_c2");
      rd(3'd3, 32'hA5, 1'b0, "cap_c3");
      rd(3'd1, 32'd0, 1'b0, "unmapped1");
      wr(3'd0, 32'hFF);
      rd(3'd0, 32'hA5, 1'b0, "data_ro");
      wr(3'd3, 32'hFF);
      rd(3'd3, 32'd0, 1'b0, "w1c_all");

      in_port = 8'hA4;
      idle(4);
      rd(3'd3, 32'd0, 1'b0, "fall_ignored");
      wr(3'd2, 32'hFFFF_FF01);
      rd(3'd2, 32'h01, 1'b0, "mask_rd");
      in_port = 8'hA5;
      rd(3'd3, 32'd0, 1'b0, "irq_d0");
      rd(3'd3, 32'd0, 1'b0, "irq_d1");
      rd(3'd3, 32'd0, 1'b0, "irq_d2");
      rd(3'd3, 32'h01, 1'b1, "irq_d3");
      wr(3'd3, 32'h01);
      rd(3'd3, 32'd0, 1'b0, "w1c_irq_clear");

      in_port = 8'hA1;
      idle(4);
      rd(3'd3, 32'd0, 1'b0, "fall2_ignored");
      in_port = 8'hA5;
      idle(2);
      wr(3'd3, 32'h04);
      rd(3'd3, 32'h04, 1'b0, "edge_beats_w1c");
      wr(3'd3, 32'h04);
      rd(3'd3, 32'd0, 1'b0, "w1c_bit2");

      wr(3'd2, 32'h00);
      in_port = 8'h00;
      idle(4);
      wr(3'd3, 32'hFF);
      in_port = 8'hFF;
      idle(4);
      rd(3'd3, 32'hFF, 1'b0, "mask0_noirq");
      wr(3'd2, 32'h80);
      rd(3'd2, 32'h80, 1'b1, "mask80_irq");
      for (int a = 4; a < 8; a++) rd(3'(a), 32'd0, 1'b1, $sformatf("unmapped%0d", a));

      reset_n = 1'b0;
      rd(3'd3, 32'd0, 1'b0, "rst_cap");
      rd(3'd2, 32'd0, 1'b0, "rst_mask");
      rd(3'd0, 32'd0, 1'b0, "rst_data");
      reset_n = 1'b1;
`endif

      idle(2);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
